// File: rtl/pacman_behavior.sv
// Pac-Man movement controller: latches joystick heading and steps one board block per move tick
// unless the target is a wall or an edge. Define PAC_TUNNEL_EN to wrap horizontal edges.
module pacman_behavior #(
  parameter int unsigned COLS        = 32,
  parameter int unsigned ROWS        = 24,
  parameter logic [9:0]  START_BLOCK = 10'd560,
  parameter int unsigned MOVE_DIV    = 2_500_000,
  parameter logic [3:0]  WALL_TYPE   = 4'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic [9:0] query_addr,
  input  logic [3:0] tile_type,
  output logic [9:0] curr_block,
  output logic [9:0] next_block,
  output logic [1:0] dir,
  output logic       moving
);

  localparam int         CNT_W    = $clog2(MOVE_DIV);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MOVE_DIV - 1);
  localparam logic [9:0] COLS_W   = 10'(COLS);
  localparam logic [4:0] LAST_COL = 5'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [2:0] {IDLE, QRY_D, WAIT_D, CHK_D, QRY_C, WAIT_C, CHK_C} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       curr_q, curr_d;
  logic [9:0]       qaddr_q, qaddr_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       desired_q, desired_d;
  logic [1:0]       req_q, req_d;
  logic             moving_q, moving_d;

  logic [10:0]      nb_try;
  logic [10:0]      nb_head;
  logic [1:0]       try_dir;
  logic             legal;
  logic             tick;

  // Returns {edge_blocked, target}; target equals idx when blocked.
  function automatic logic [10:0] nbr_f(input logic [9:0] idx, input logic [1:0] d);
    logic [4:0] row;
    logic [4:0] col;
    logic       blk;
    logic [9:0] tgt;
    row = idx[9:5];
    col = idx[4:0];
    blk = 1'b0;
    tgt = idx;
    case (d)
      2'd0: if (row == 5'd0) blk = 1'b1; else tgt = idx - COLS_W;
      2'd1: if (row == LAST_ROW) blk = 1'b1; else tgt = idx + COLS_W;
      2'd2: begin
        if (col == 5'd0) begin
`ifdef PAC_TUNNEL_EN
          tgt = {row, LAST_COL};
`else
          blk = 1'b1;
`endif
        end else begin
          tgt = idx - 10'd1;
        end
      end
      default: begin
        if (col == LAST_COL) begin
`ifdef PAC_TUNNEL_EN
          tgt = {row, 5'd0};
`else
          blk = 1'b1;
`endif
        end else begin
          tgt = idx + 10'd1;
        end
      end
    endcase
    return {blk, tgt};
  endfunction

  assign tick    = (cnt_q == LAST_CNT);
  // The heading requested at the tick is frozen in req_q so mid-sequence button changes wait.
  assign try_dir = (state_q == QRY_D || state_q == WAIT_D || state_q == CHK_D) ? req_q : dir_q;
  assign nb_try  = nbr_f(curr_q, try_dir);
  assign nb_head = nbr_f(curr_q, dir_q);
  assign legal   = !nb_try[10] && (tile_type != WALL_TYPE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    curr_d    = curr_q;
    qaddr_d   = qaddr_q;
    dir_d     = dir_q;
    req_d     = req_q;
    moving_d  = moving_q;
    desired_d = desired_q;
    if (up)         desired_d = 2'd0;
    else if (down)  desired_d = 2'd1;
    else if (left)  desired_d = 2'd2;
    else if (right) desired_d = 2'd3;

    case (state_q)
      IDLE: if (tick) begin
        req_d   = desired_q;
        state_d = QRY_D;
      end
      QRY_D: begin
        qaddr_d = nb_try[9:0];
        state_d = WAIT_D;
      end
      WAIT_D: state_d = CHK_D;
      CHK_D: begin
        if (legal) begin
          curr_d   = nb_try[9:0];
          dir_d    = req_q;
          moving_d = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d  = QRY_C;
        end
      end
      QRY_C: begin
        qaddr_d = nb_try[9:0];
        state_d = WAIT_C;
      end
      WAIT_C: state_d = CHK_C;
      CHK_C: begin
        if (legal) curr_d = nb_try[9:0];
        moving_d = legal;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      curr_q    <= START_BLOCK;
      qaddr_q   <= START_BLOCK;
      dir_q     <= 2'd2;
      desired_q <= 2'd2;
      req_q     <= 2'd2;
      moving_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      curr_q    <= curr_d;
      qaddr_q   <= qaddr_d;
      dir_q     <= dir_d;
      desired_q <= desired_d;
      req_q     <= req_d;
      moving_q  <= moving_d;
    end
  end

  assign query_addr = qaddr_q;
  assign curr_block = curr_q;
  assign next_block = nb_head[9:0];
  assign dir        = dir_q;
  assign moving     = moving_q;

endmodule

// File: tb/tb_pacman_behavior.sv
// Randomised and directed bench for pacman_behavior against a tick-level board model.
module tb_pacman_behavior;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [3:0] tile_type = 4'd0;
  logic [9:0] query_addr, curr_block, next_block;
  logic [1:0] dir;
  logic       moving;

  logic [3:0] ram [0:767];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m_cur, m_dir, m_des;
  bit m_mov;

  pacman_behavior #(.MOVE_DIV(8)) dut (
    .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .query_addr(query_addr), .tile_type(tile_type), .curr_block(curr_block),
    .next_block(next_block), .dir(dir), .moving(moving)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tile_type <= (query_addr < 10'd768) ? ram[query_addr] : 4'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic void m_nbr(input int idx, input int d, output int tgt, output bit blk);
    int row = idx / 32;
    int col = idx % 32;
    blk = 1'b0;
    tgt = idx;
    if (d == 0) begin
      if (row == 0) blk = 1'b1; else tgt = idx - 32;
    end else if (d == 1) begin
      if (row == 23) blk = 1'b1; else tgt = idx + 32;
    end else if (d == 2) begin
      if (col == 0) begin
`ifdef PAC_TUNNEL_EN
        tgt = row * 32 + 31;
`else
        blk = 1'b1;
`endif
      end else tgt = idx - 1;
    end else begin
      if (col == 31) begin
`ifdef PAC_TUNNEL_EN
        tgt = row * 32;
`else
        blk = 1'b1;
`endif
      end else tgt = idx + 1;
    end
  endfunction

  task automatic clear_ram();
    for (int i = 0; i < 768; i++) ram[i] = 4'd0;
  endtask

  task automatic model_reset();
    m_cur = 560; m_dir = 2; m_des = 2; m_mov = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_curr"}, curr_block, 560);
    chk({tag, "_qaddr"}, query_addr, 560);
    chk({tag, "_dir"}, dir, 2);
    chk({tag, "_moving"}, moving, 0);
    chk({tag, "_next"}, next_block, 559);
  endtask

  task automatic do_reset();
    {up, down, left, right} = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    model_reset();
  endtask

  // Drives one tick with buttons {up,down,left,right}; checks curr_block every cycle of the sequence.
  task automatic run_tick(input logic [3:0] btns);
    int old, tq, tf, tn, upd;
    bit bq, bf, bn;
    {up, down, left, right} = btns;
    if (btns[3]) m_des = 0;
    else if (btns[2]) m_des = 1;
    else if (btns[1]) m_des = 2;
    else if (btns[0]) m_des = 3;
    while (cyc == 0 || cyc % 8 != 0) step();
    old = m_cur;
    upd = 0;
    m_nbr(m_cur, m_des, tq, bq);
    if (!bq && ram[tq] != 4'd1) begin
      m_cur = tq; m_dir = m_des; m_mov = 1'b1; upd = 3;
    end else begin
      m_nbr(m_cur, m_dir, tf, bf);
      if (!bf && ram[tf] != 4'd1) begin
        m_cur = tf; m_mov = 1'b1; upd = 6;
      end else m_mov = 1'b0;
    end
    for (int s = 1; s <= 6; s++) begin
      step();
      if (s == 1 && !bq) chk("qaddr", query_addr, tq);
      chk("curr_seq", curr_block, (upd != 0 && s >= upd) ? m_cur : old);
    end
    m_nbr(m_cur, m_dir, tn, bn);
    chk("dir", dir, m_dir);
    chk("moving", moving, m_mov);
    chk("next", next_block, tn);
    $display("tick btn=%b from=%0d to=%0d dir=%0d moving=%0d", btns, old, curr_block, dir, moving);
  endtask

  initial begin
    clear_ram();
    model_reset();

    // Free movement left from the start block.
    do_reset();
    run_tick(4'b0000);
    chk("free1", curr_block, 559);
    run_tick(4'b0000);
    chk("free2", curr_block, 558);

    // Up blocked by a wall: falls back to the current heading.
    do_reset();
    ram[528] = 4'd1;
    run_tick(4'b1000);
    chk("fb_curr", curr_block, 559);
    chk("fb_dir", dir, 2);

    // Both directions walled: no move.
    do_reset();
    ram[559] = 4'd1;
    run_tick(4'b1000);
    chk("stuck_curr", curr_block, 560);
    chk("stuck_moving", moving, 0);
    clear_ram();

    // Reach block 32 heading left, then push past the left edge.
    do_reset();
    for (int i = 0; i < 16; i++) run_tick(4'b1000);
    for (int i = 0; i < 16; i++) run_tick(4'b0010);
    chk("at32", curr_block, 32);
    run_tick(4'b0000);
`ifdef PAC_TUNNEL_EN
    chk("tunnel", curr_block, 63);
`else
    chk("edge_left", curr_block, 32);
    chk("edge_left_mv", moving, 0);
`endif

    // Reach block 5 on row 0, hold up, and reset during WAIT_D.
    do_reset();
    for (int i = 0; i < 17; i++) run_tick(4'b1000);
    for (int i = 0; i < 11; i++) run_tick(4'b0010);
    chk("at5", curr_block, 5);
    {up, down, left, right} = 4'b1000;
    while (cyc == 0 || cyc % 8 != 0) step();
    step();
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    {up, down, left, right} = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    model_reset();
    run_tick(4'b0000);
    chk("after_midrst", curr_block, 559);

    // Random walk with randomised neighbour tiles.
    do_reset();
    for (int n = 0; n < 150; n++) begin
      logic [3:0] btns;
      for (int d = 0; d < 4; d++) begin
        int t;
        bit b;
        int v;
        m_nbr(m_cur, d, t, b);
        if (!b) begin
          if ($urandom_range(0, 2) == 0) v = 1;
          else begin
            v = $urandom_range(0, 15);
            if (v == 1) v = 0;
          end
          ram[t] = 4'(v);
        end
      end
      btns = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) btns = 4'b0000;
      run_tick(btns);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
